// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  // Default RAM byte-address width.
  localparam int RamAddrBus = 17;

  // Controller states.
  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_DONE = 2'd3
  } mc_state_t;

  // Data access size codes (2'b00 behaves like a byte access).
  localparam logic [1:0] MemByte = 2'b01;
  localparam logic [1:0] MemHalf = 2'b10;
  localparam logic [1:0] MemWord = 2'b11;

  // Which requester owns the access in flight.
  typedef enum logic {
    OwnInst = 1'b0,
    OwnData = 1'b1
  } owner_t;

  // Number of bytes moved for a given size code.
  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      MemHalf: size_len = 3'd2;
      MemWord: size_len = 3'd4;
      default: size_len = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves instruction fetches and data
// loads/stores from a byte-wide synchronous RAM, data requests first.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = RamAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  mc_state_t         state_reg;
  owner_t            owner_reg;
  logic [2:0]        len_reg;
  logic [2:0]        cnt_reg;
  logic [RAM_AW-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       word_reg;
  logic [31:0]       word_next;
  logic [31:0]       if_data_reg;
  logic              if_done_reg;
  logic [31:0]       mem_rdata_reg;
  logic              mem_done_reg;
  logic [RAM_AW-1:0] ram_a_reg;
  logic              ram_wr_reg;
  logic [7:0]        ram_din_reg;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

  // Lane k-1 takes the RAM byte that was addressed in the previous cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_next[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? ram_dout
                                                          : word_reg[8*gi +: 8];
  end

  assign if_data   = if_data_reg;
  assign mem_rdata = mem_rdata_reg;
  assign mem_done  = mem_done_reg;
  assign ram_a     = ram_a_reg;
  assign ram_wr    = ram_wr_reg;
  assign ram_din   = ram_din_reg;
  // A branch arriving during the fetch's done cycle still cancels the pulse.
  assign if_done   = if_done_reg & ~if_flush;

  // Controller FSM: arbitration, byte sequencing, lane assembly, done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= MC_IDLE;
      owner_reg     <= OwnInst;
      len_reg       <= 3'd0;
      cnt_reg       <= 3'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      word_reg      <= 32'd0;
      if_data_reg   <= 32'd0;
      if_done_reg   <= 1'b0;
      mem_rdata_reg <= 32'd0;
      mem_done_reg  <= 1'b0;
      ram_a_reg     <= '0;
      ram_wr_reg    <= 1'b0;
      ram_din_reg   <= 8'd0;
    end else begin
      case (state_reg)
        MC_IDLE: begin
          if (mem_req) begin
            owner_reg <= OwnData;
            addr_reg  <= mem_addr[RAM_AW-1:0];
            ram_a_reg <= mem_addr[RAM_AW-1:0];
            len_reg   <= size_len(mem_size);
            cnt_reg   <= 3'd0;
            word_reg  <= 32'd0;
            if (mem_we) begin
              state_reg   <= MC_WR;
              ram_wr_reg  <= 1'b1;
              ram_din_reg <= mem_wdata[7:0];
              wdata_reg   <= mem_wdata >> 8;
            end else begin
              state_reg <= MC_RD;
            end
          end else if (if_req && !if_flush) begin
            owner_reg <= OwnInst;
            addr_reg  <= if_addr[RAM_AW-1:0];
            ram_a_reg <= if_addr[RAM_AW-1:0];
            len_reg   <= 3'd4;
            cnt_reg   <= 3'd0;
            word_reg  <= 32'd0;
            state_reg <= MC_RD;
          end
        end

        MC_RD: begin
          if (owner_reg == OwnInst && if_flush) begin
            // Branch taken: drop the fetch without touching if_data.
            state_reg <= MC_IDLE;
          end else begin
            word_reg <= word_next;
            if (cnt_reg == len_reg) begin
              state_reg <= MC_DONE;
              if (owner_reg == OwnInst) begin
                if_data_reg <= word_next;
                if_done_reg <= 1'b1;
              end else begin
                mem_rdata_reg <= word_next;
                mem_done_reg  <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 3'd1;
              if (cnt_reg + 3'd1 < len_reg) begin
                ram_a_reg <= addr_reg + RAM_AW'(cnt_reg + 3'd1);
              end
            end
          end
        end

        MC_WR: begin
          if (cnt_reg == len_reg - 3'd1) begin
            state_reg    <= MC_DONE;
            ram_wr_reg   <= 1'b0;
            mem_done_reg <= 1'b1;
          end else begin
            cnt_reg     <= cnt_reg + 3'd1;
            ram_a_reg   <= addr_reg + RAM_AW'(cnt_reg + 3'd1);
            ram_din_reg <= wdata_reg[7:0];
            wdata_reg   <= wdata_reg >> 8;
          end
        end

        default: begin
          // MC_DONE: pulse lasts exactly one cycle, no request sampling here.
          if_done_reg  <= 1'b0;
          mem_done_reg <= 1'b0;
          state_reg    <= MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 17;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_flush;
  logic [31:0]   if_data;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [1:0]    mem_size;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  logic [7:0] ram_mem [0:(1<<AW)-1];

  int n_total;
  int n_pass;

  mem_ctrl #(.RAM_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_data  (if_data),
    .if_done  (if_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_size (mem_size),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous byte RAM: write-enable and registered read.
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_a] <= ram_din;
    ram_dout <= ram_mem[ram_a];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  int          md_cnt, id_cnt, md_cyc, id_cyc;
  logic [31:0] md_val, id_val;
  logic        wr_seen;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_size = 2'b00; mem_wdata = 32'd0;
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 8'h00;
    ram_mem[17'h00100] = 8'h13; ram_mem[17'h00101] = 8'h05;
    ram_mem[17'h00102] = 8'h10; ram_mem[17'h00103] = 8'h00;
    ram_mem[17'h00040] = 8'h11; ram_mem[17'h00041] = 8'h22;
    ram_mem[17'h00042] = 8'h33; ram_mem[17'h00043] = 8'h44;
    ram_mem[17'h00200] = 8'h93; ram_mem[17'h00201] = 8'h00;
    ram_mem[17'h00202] = 8'h10; ram_mem[17'h00203] = 8'h00;
    ram_mem[17'h00300] = 8'h55; ram_mem[17'h00301] = 8'h66;
    ram_mem[17'h1FFFF] = 8'hAA; ram_mem[17'h00000] = 8'hBB;
    ram_mem[17'h00001] = 8'hCC; ram_mem[17'h00002] = 8'hDD;

    // ---- reset state ----
    @(negedge clk); @(negedge clk);
    check_eq("rst_if_done", {31'd0, if_done}, 32'd0);
    check_eq("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check_eq("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check_eq("rst_ram_a", 32'(ram_a), 32'd0);
    check_eq("rst_if_data", if_data, 32'd0);
    check_eq("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b1;
    $display("reset released");

    // ---- word fetch at 0x100 ----
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("fetch_ram_a%0d", k), 32'(ram_a), 32'h100 + 32'(k));
      check_eq($sformatf("fetch_ram_wr%0d", k), {31'd0, ram_wr}, 32'd0);
    end
    @(negedge clk);
    check_eq("fetch_done_early", {31'd0, if_done}, 32'd0);
    @(negedge clk);
    check_eq("fetch_done", {31'd0, if_done}, 32'd1);
    check_eq("fetch_data", if_data, 32'h0010_0513);
    if_req = 1'b0;
    @(negedge clk);
    check_eq("fetch_done_pulse", {31'd0, if_done}, 32'd0);
    $display("fetch 0x100 -> 0x%08h", if_data);

    // ---- half store at 0x2001, then byte load at 0x2002 ----
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_2001;
    mem_size = MemHalf; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("st_wr0", {31'd0, ram_wr}, 32'd1);
    check_eq("st_a0", 32'(ram_a), 32'h2001);
    check_eq("st_din0", {24'd0, ram_din}, 32'hEF);
    @(negedge clk);
    check_eq("st_wr1", {31'd0, ram_wr}, 32'd1);
    check_eq("st_a1", 32'(ram_a), 32'h2002);
    check_eq("st_din1", {24'd0, ram_din}, 32'hBE);
    @(negedge clk);
    check_eq("st_done", {31'd0, mem_done}, 32'd1);
    check_eq("st_wr_off", {31'd0, ram_wr}, 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    check_eq("st_mem2001", {24'd0, ram_mem[17'h02001]}, 32'hEF);
    check_eq("st_mem2002", {24'd0, ram_mem[17'h02002]}, 32'hBE);
    check_eq("st_mem2003", {24'd0, ram_mem[17'h02003]}, 32'h00);
    $display("store half 0x2001 <- 0xBEEF");
    mem_req = 1'b1; mem_addr = 32'h0000_2002; mem_size = MemByte;
    @(negedge clk);
    check_eq("ldb_a", 32'(ram_a), 32'h2002);
    @(negedge clk);
    check_eq("ldb_done_early", {31'd0, mem_done}, 32'd0);
    @(negedge clk);
    check_eq("ldb_done", {31'd0, mem_done}, 32'd1);
    check_eq("ldb_data", mem_rdata, 32'h0000_00BE);
    mem_req = 1'b0;
    $display("load byte 0x2002 -> 0x%08h", mem_rdata);
    @(negedge clk);

    // ---- simultaneous data word load and fetch ----
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0040; mem_size = MemWord;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    md_cnt = 0; id_cnt = 0; md_cyc = -1; id_cyc = -1; md_val = 32'd0; id_val = 32'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_done) begin md_cnt++; md_cyc = c; md_val = mem_rdata; mem_req = 1'b0; end
      if (if_done)  begin id_cnt++; id_cyc = c; id_val = if_data;   if_req  = 1'b0; end
    end
    check_eq("arb_mem_cnt", 32'(md_cnt), 32'd1);
    check_eq("arb_mem_cyc", 32'(md_cyc), 32'd5);
    check_eq("arb_mem_data", md_val, 32'h4433_2211);
    check_eq("arb_if_cnt", 32'(id_cnt), 32'd1);
    check_eq("arb_if_cyc", 32'(id_cyc), 32'd12);
    check_eq("arb_if_data", id_val, 32'h0010_0513);
    $display("arbitration: data 0x%08h then fetch 0x%08h", md_val, id_val);

    // ---- fetch flushed in its 3rd RD cycle, then refetch at 0x200 ----
    if_req = 1'b1; if_addr = 32'h0000_0300;
    id_cnt = 0; id_cyc = -1; id_val = 32'd0; wr_seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      wr_seen = wr_seen | ram_wr;
      if (if_done) begin id_cnt++; id_cyc = c; id_val = if_data; if_req = 1'b0; end
      if (c == 2) if_flush = 1'b1;
      if (c == 3) begin
        check_eq("flush_state_idle", 32'(dut.state_reg), 32'(MC_IDLE));
        if_flush = 1'b0; if_addr = 32'h0000_0200;
      end
    end
    check_eq("flush_if_cnt", 32'(id_cnt), 32'd1);
    check_eq("flush_if_cyc", 32'(id_cyc), 32'd9);
    check_eq("flush_if_data", id_val, 32'h0010_0093);
    check_eq("flush_no_wr", {31'd0, wr_seen}, 32'd0);
    $display("flushed fetch, refetch 0x200 -> 0x%08h", id_val);

    // ---- reset during a word store: bytes 0 and 1 land, no done ----
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_3000;
    mem_size = MemWord; mem_wdata = 32'hA1B2_C3D4;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("rstw_wr_before", {31'd0, ram_wr}, 32'd1);
    rst = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0;
    #1;
    check_eq("rstw_wr", {31'd0, ram_wr}, 32'd0);
    check_eq("rstw_ram_a", 32'(ram_a), 32'd0);
    check_eq("rstw_din", {24'd0, ram_din}, 32'd0);
    check_eq("rstw_if_data", if_data, 32'd0);
    check_eq("rstw_mem_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    md_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_done) md_cnt++;
    end
    check_eq("rstw_no_done", 32'(md_cnt), 32'd0);
    check_eq("rstw_b0", {24'd0, ram_mem[17'h03000]}, 32'hD4);
    check_eq("rstw_b1", {24'd0, ram_mem[17'h03001]}, 32'hC3);
    check_eq("rstw_b2", {24'd0, ram_mem[17'h03002]}, 32'h00);
    check_eq("rstw_b3", {24'd0, ram_mem[17'h03003]}, 32'h00);
    $display("store aborted by reset after 2 bytes");

    // ---- word load wrapping past the top of the RAM ----
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0001_FFFF; mem_size = MemWord;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("wrap_a%0d", k), 32'(ram_a), (32'h1FFFF + 32'(k)) & 32'h1FFFF);
    end
    @(negedge clk);
    @(negedge clk);
    check_eq("wrap_done", {31'd0, mem_done}, 32'd1);
    check_eq("wrap_data", mem_rdata, 32'hDDCC_BBAA);
    mem_req = 1'b0;
    $display("wrap load 0x1FFFF -> 0x%08h", mem_rdata);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
